// File: rtl/system_top_if.sv
// UART pins and receive status of system_top, bundled for the top-level port.
interface system_top_if;
   logic rx_in;
   logic tx_out;
   logic parity_error;
   logic stop_error;

   modport master (output rx_in, input tx_out, input parity_error, input stop_error);
   modport slave  (input rx_in, output tx_out, output parity_error, output stop_error);
endinterface

// File: rtl/system_top.sv
// UART command processor. RX frames drive a small controller that writes the
// register file, reads it back or runs the ALU; responses leave through a
// byte FIFO and the TX.
//
// state            | meaning
// R_IDLE           | waiting for a falling edge on the synchronised line
// R_START          | counting to the middle of the start bit
// R_DATA           | sampling data[0..7]
// R_PARITY         | sampling the parity bit
// R_STOP           | sampling the stop bit, then straight back to R_IDLE
// T_IDLE           | waiting for a byte in the FIFO
// T_START..T_STOP  | driving start, data, parity, stop (busy high)
// T_GAP            | one forced idle bit between frames (busy low)
// C_IDLE           | waiting for a command byte
// C_WR_ADDR/DATA   | write command: address, then data
// C_RD_ADDR        | read command: address, register value is pushed
// C_ALU_A/B        | operand bytes into reg0/reg1
// C_ALU_FUNC       | function code after new operands, result pushed
// C_ALU_NOP_FUNC   | function code on the current reg0/reg1

module system_top_regfile #(
   parameter int data_width      = 8,
   parameter int rg_addres_width = 4,
   parameter int reg_file_depth  = 16
) (
   input  logic                       ref_clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [rg_addres_width-1:0] wr_addr,
   input  logic [data_width-1:0]      wr_data,
   input  logic [rg_addres_width-1:0] rd_addr,
   output logic [data_width-1:0]      rd_data,
   output logic [data_width-1:0]      reg0,
   output logic [data_width-1:0]      reg1,
   output logic [data_width-1:0]      reg2
);
   logic [data_width-1:0] regs_q [reg_file_depth];
   logic [data_width-1:0] regs_d [reg_file_depth];

   // single write port with address decode
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
   end

   // reg2 leaves reset as parity on, type 0, PRESCALE 32
   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < reg_file_depth; i++) regs_q[i] <= '0;
         regs_q[2] <= data_width'(8'h81);
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rd_data = regs_q[rd_addr];
   assign reg0    = regs_q[0];
   assign reg1    = regs_q[1];
   assign reg2    = regs_q[2];
endmodule

module system_top #(
   parameter int data_width        = 8,
   parameter int addre_width       = 4,
   parameter int alu_func_width    = 4,
   parameter int num_sync_stage    = 2,
   parameter int rg_addres_width   = 4,
   parameter int reg_file_depth    = 16,
   parameter int FIFO_DEPTH        = 8,
   parameter int FIFO_addres_width = 3
) (
   input logic         ref_clk,
   input logic         rst,
   system_top_if.slave uart
);
   localparam int RW = 2 * data_width;
   localparam int CW = FIFO_addres_width + 1;

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_state_t;
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP, T_GAP} tx_state_t;
   typedef enum logic [2:0] {C_IDLE, C_WR_ADDR, C_WR_DATA, C_RD_ADDR, C_ALU_A, C_ALU_B,
                             C_ALU_FUNC, C_ALU_NOP_FUNC} ctl_state_t;

   function automatic logic [5:0] eff_presc(input logic [7:0] cfg);
      return (cfg[7:2] < 6'd4) ? 6'd4 : cfg[7:2];
   endfunction

   function automatic logic par_bit(input logic [7:0] d, input logic xor_type);
      return xor_type ? ^d : ~^d;
   endfunction

   logic [num_sync_stage-1:0] sync_q, sync_d;
   logic rx_s, rx_prev_q, rx_prev_d, fall;
   rx_state_t rx_st_q, rx_st_d;
   logic [7:0] rx_cfg_q, rx_cfg_d, rx_sh_q, rx_sh_d;
   logic [5:0] rx_cnt_q, rx_cnt_d;
   logic [2:0] rx_idx_q, rx_idx_d;
   logic rx_par_q, rx_par_d, perr_q, perr_d, serr_q, serr_d, rx_vld_q, rx_vld_d;

   tx_state_t tx_st_q, tx_st_d;
   logic [7:0] tx_cfg_q, tx_cfg_d, tx_sh_q, tx_sh_d;
   logic [5:0] tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_idx_q, tx_idx_d;
   logic tx_busy, tx_bit, pop;

   logic [data_width-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [FIFO_addres_width-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic push, do_push;
   logic [data_width-1:0] push_data;

   ctl_state_t ctl_st_q, ctl_st_d;
   logic [addre_width-1:0] addr_q, addr_d;
   logic pend_q, pend_d;
   logic [data_width-1:0] pend_byte_q, pend_byte_d;
   logic [alu_func_width-1:0] alu_func;
   logic [RW-1:0] alu;

   logic [data_width-1:0] reg0, reg1, reg2, rf_rdata, rf_wdata;
   logic [rg_addres_width-1:0] rf_waddr;
   logic rf_we;

   system_top_regfile #(
      .data_width(data_width), .rg_addres_width(rg_addres_width), .reg_file_depth(reg_file_depth)
   ) u_rf (
      .ref_clk(ref_clk), .rst(rst), .wr_en(rf_we), .wr_addr(rf_waddr), .wr_data(rf_wdata),
      .rd_addr(rx_sh_q[rg_addres_width-1:0]), .rd_data(rf_rdata),
      .reg0(reg0), .reg1(reg1), .reg2(reg2)
   );

   assign sync_d    = {sync_q[num_sync_stage-2:0], uart.rx_in};
   assign rx_s      = sync_q[num_sync_stage-1];
   assign rx_prev_d = rx_s;
   assign fall      = rx_prev_q & ~rx_s;

   // RX framing: one sample per bit, half a prescale into the bit
   always_comb begin
      rx_st_d  = rx_st_q;  rx_cfg_d = rx_cfg_q; rx_sh_d = rx_sh_q; rx_cnt_d = rx_cnt_q;
      rx_idx_d = rx_idx_q; rx_par_d = rx_par_q; perr_d  = perr_q;  serr_d   = serr_q;
      rx_vld_d = 1'b0;
      if (rx_st_q != R_IDLE) rx_cnt_d = rx_cnt_q - 6'd1;
      if (rx_st_q == R_IDLE) begin
         if (fall) begin
            rx_cfg_d = reg2;
            rx_cnt_d = (eff_presc(reg2) >> 1) - 6'd1;
            rx_st_d  = R_START;
         end
      end else if (rx_cnt_q == 6'd0) begin
         rx_cnt_d = eff_presc(rx_cfg_q) - 6'd1;
         case (rx_st_q)
            R_START: begin
               rx_idx_d = 3'd0;
               rx_st_d  = rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: begin
               rx_sh_d  = {rx_s, rx_sh_q[7:1]};
               rx_idx_d = rx_idx_q + 3'd1;
               if (rx_idx_q == 3'd7) rx_st_d = rx_cfg_q[0] ? R_PARITY : R_STOP;
            end
            R_PARITY: begin
               rx_par_d = rx_s;
               rx_st_d  = R_STOP;
            end
            default: begin
               perr_d   = rx_cfg_q[0] && (rx_par_q != par_bit(rx_sh_q, rx_cfg_q[1]));
               serr_d   = ~rx_s;
               rx_vld_d = ~perr_d & ~serr_d;
               rx_st_d  = R_IDLE;
            end
         endcase
      end
   end

   // TX framing: configuration captured when a byte is popped
   always_comb begin
      tx_st_d = tx_st_q; tx_cfg_d = tx_cfg_q; tx_sh_d = tx_sh_q;
      tx_cnt_d = tx_cnt_q; tx_idx_d = tx_idx_q; pop = 1'b0;
      if (tx_st_q != T_IDLE) tx_cnt_d = tx_cnt_q - 6'd1;
      if (tx_st_q == T_IDLE) begin
         if (fifo_cnt_q != '0) begin
            pop      = 1'b1;
            tx_cfg_d = reg2;
            tx_sh_d  = fifo_mem_q[rd_ptr_q];
            tx_cnt_d = eff_presc(reg2) - 6'd1;
            tx_idx_d = 3'd0;
            tx_st_d  = T_START;
         end
      end else if (tx_cnt_q == 6'd0) begin
         tx_cnt_d = eff_presc(tx_cfg_q) - 6'd1;
         case (tx_st_q)
            T_START:  tx_st_d = T_DATA;
            T_DATA: begin
               tx_idx_d = tx_idx_q + 3'd1;
               if (tx_idx_q == 3'd7) tx_st_d = tx_cfg_q[0] ? T_PARITY : T_STOP;
            end
            T_PARITY: tx_st_d = T_STOP;
            T_STOP:   tx_st_d = T_GAP;
            default:  tx_st_d = T_IDLE;
         endcase
      end
   end

   // line level for the current TX bit
   always_comb begin
      tx_bit = 1'b1;
      case (tx_st_q)
         T_START:  tx_bit = 1'b0;
         T_DATA:   tx_bit = tx_sh_q[tx_idx_q];
         T_PARITY: tx_bit = par_bit(tx_sh_q, tx_cfg_q[1]);
         default:  tx_bit = 1'b1;
      endcase
   end

   assign tx_busy = (tx_st_q == T_START) || (tx_st_q == T_DATA) ||
                    (tx_st_q == T_PARITY) || (tx_st_q == T_STOP);
   assign uart.tx_out       = tx_busy ? tx_bit : 1'b1;
   assign uart.parity_error = perr_q;
   assign uart.stop_error   = serr_q;

   // FIFO pointers; a push while full is dropped
   always_comb begin
      do_push    = push && (fifo_cnt_q != CW'(FIFO_DEPTH));
      wr_ptr_d   = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q + CW'(do_push) - CW'(pop);
   end

   // ALU on reg0/reg1
   always_comb begin
      alu = '0;
      case (alu_func)
         4'd0:    alu = RW'(reg0) + RW'(reg1);
         4'd1:    alu = RW'(reg0) - RW'(reg1);
         4'd2:    alu = RW'(reg0) * RW'(reg1);
         4'd3:    alu = (reg1 == '0) ? '0 : RW'(reg0 / reg1);
         4'd4:    alu = RW'(reg0 & reg1);
         4'd5:    alu = RW'(reg0 | reg1);
         4'd6:    alu = RW'(~(reg0 & reg1));
         4'd7:    alu = RW'(~(reg0 | reg1));
         4'd8:    alu = RW'(reg0 ^ reg1);
         4'd9:    alu = RW'(~(reg0 ^ reg1));
         4'd10:   alu = RW'(reg0 == reg1);
         4'd11:   alu = RW'(reg0 > reg1);
         4'd12:   alu = RW'(reg0 < reg1);
         4'd13:   alu = RW'(reg0 >> 1);
         4'd14:   alu = RW'(reg0) << 1;
         default: alu = '0;
      endcase
   end

   // command decode; the MS result byte is pushed the cycle after the LS byte
   always_comb begin
      ctl_st_d = ctl_st_q; addr_d = addr_q; pend_d = 1'b0; pend_byte_d = pend_byte_q;
      rf_we = 1'b0; rf_waddr = rg_addres_width'(addr_q); rf_wdata = rx_sh_q;
      push = pend_q; push_data = pend_byte_q;
      alu_func = rx_sh_q[alu_func_width-1:0];
      if (rx_vld_q) begin
         case (ctl_st_q)
            C_IDLE: begin
               case (rx_sh_q)
                  8'hAA:   ctl_st_d = C_WR_ADDR;
                  8'hBB:   ctl_st_d = C_RD_ADDR;
                  8'hCC:   ctl_st_d = C_ALU_A;
                  8'hDD:   ctl_st_d = C_ALU_NOP_FUNC;
                  default: ctl_st_d = C_IDLE;
               endcase
            end
            C_WR_ADDR: begin
               addr_d   = rx_sh_q[addre_width-1:0];
               ctl_st_d = C_WR_DATA;
            end
            C_WR_DATA: begin
               rf_we    = 1'b1;
               ctl_st_d = C_IDLE;
            end
            C_RD_ADDR: begin
               push      = 1'b1;
               push_data = rf_rdata;
               ctl_st_d  = C_IDLE;
            end
            C_ALU_A: begin
               rf_we    = 1'b1;
               rf_waddr = '0;
               ctl_st_d = C_ALU_B;
            end
            C_ALU_B: begin
               rf_we    = 1'b1;
               rf_waddr = rg_addres_width'(1);
               ctl_st_d = C_ALU_FUNC;
            end
            default: begin
               push        = 1'b1;
               push_data   = alu[data_width-1:0];
               pend_d      = 1'b1;
               pend_byte_d = alu[RW-1:data_width];
               ctl_st_d    = C_IDLE;
            end
         endcase
      end
   end

   // all control state; synchroniser resets to the idle-high line level
   always_ff @(posedge ref_clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1; rx_prev_q <= 1'b1;
         rx_st_q <= R_IDLE; rx_cfg_q <= '0; rx_sh_q <= '0; rx_cnt_q <= '0; rx_idx_q <= '0;
         rx_par_q <= 1'b0; perr_q <= 1'b0; serr_q <= 1'b0; rx_vld_q <= 1'b0;
         tx_st_q <= T_IDLE; tx_cfg_q <= '0; tx_sh_q <= '0; tx_cnt_q <= '0; tx_idx_q <= '0;
         wr_ptr_q <= '0; rd_ptr_q <= '0; fifo_cnt_q <= '0;
         ctl_st_q <= C_IDLE; addr_q <= '0; pend_q <= 1'b0; pend_byte_q <= '0;
      end else begin
         sync_q <= sync_d; rx_prev_q <= rx_prev_d;
         rx_st_q <= rx_st_d; rx_cfg_q <= rx_cfg_d; rx_sh_q <= rx_sh_d; rx_cnt_q <= rx_cnt_d;
         rx_idx_q <= rx_idx_d; rx_par_q <= rx_par_d; perr_q <= perr_d; serr_q <= serr_d;
         rx_vld_q <= rx_vld_d;
         tx_st_q <= tx_st_d; tx_cfg_q <= tx_cfg_d; tx_sh_q <= tx_sh_d; tx_cnt_q <= tx_cnt_d;
         tx_idx_q <= tx_idx_d;
         wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fifo_cnt_q <= fifo_cnt_d;
         ctl_st_q <= ctl_st_d; addr_q <= addr_d; pend_q <= pend_d; pend_byte_q <= pend_byte_d;
      end
   end

   // FIFO storage needs no reset; the pointers define what is valid
   always_ff @(posedge ref_clk) begin
      if (do_push) fifo_mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: tb/tb_system_top.sv
// Directed bench for system_top: drives UART command frames on rx_in and
// decodes tx_out with its own receiver.
`timescale 1ns/1ps

module tb_system_top;
   logic ref_clk = 1'b0;
   logic rst;
   system_top_if bus ();

   system_top dut (.ref_clk(ref_clk), .rst(rst), .uart(bus));

   always #5 ref_clk = ~ref_clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int tb_presc = 32;
   bit tb_par_en = 1'b1;
   bit tb_par_type = 1'b0;
   bit mon_en = 1'b0;
   logic [9:0] mon_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference receiver on tx_out: entries are {stop, parity, data}
   initial begin : monitor
      logic [7:0] d;
      logic p, s;
      forever begin
         @(negedge bus.tx_out);
         if (rst || !mon_en) continue;
         repeat (tb_presc / 2) @(posedge ref_clk);
         for (int i = 0; i < 8; i++) begin
            repeat (tb_presc) @(posedge ref_clk);
            #1 d[i] = bus.tx_out;
         end
         p = 1'b0;
         if (tb_par_en) begin
            repeat (tb_presc) @(posedge ref_clk);
            #1 p = bus.tx_out;
         end
         repeat (tb_presc) @(posedge ref_clk);
         #1 s = bus.tx_out;
         mon_q.push_back({s, p, d});
      end
   end

   task automatic drive_bit(input logic b);
      @(negedge ref_clk);
      bus.rx_in = b;
      repeat (tb_presc - 1) @(negedge ref_clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input bit bad_par = 1'b0,
                            input bit bad_stop = 1'b0);
      logic p;
      p = tb_par_type ? ^d : ~^d;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (tb_par_en) drive_bit(p ^ bad_par);
      drive_bit(~bad_stop);
      drive_bit(1'b1);
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] d, input logic p);
      logic [9:0] f;
      int t;
      t = 0;
      while (mon_q.size() == 0 && t < 3000) begin
         @(negedge ref_clk);
         t++;
      end
      check({tag, "_timeout"}, (mon_q.size() != 0), 1);
      f = (mon_q.size() != 0) ? mon_q.pop_front() : 10'h000;
      check(tag, f, {1'b1, p, d});
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      bus.rx_in = 1'b1;
      @(negedge ref_clk);
      rst = 1'b1;
      tb_presc = 32; tb_par_en = 1'b1; tb_par_type = 1'b0;
      repeat (3) @(negedge ref_clk);
   endtask

   task automatic release_reset();
      rst = 1'b0;
      mon_q.delete();
      mon_en = 1'b1;
      repeat (4) @(negedge ref_clk);
   endtask

   initial begin
      bus.rx_in = 1'b1;
      rst = 1'b1;
      do_reset();
      check("rst_tx_out", bus.tx_out, 1'b1);
      check("rst_parity_error", bus.parity_error, 1'b0);
      check("rst_stop_error", bus.stop_error, 1'b0);
      release_reset();

      // write reg10 = 0xAA, no response expected
      send_byte(8'hAA); send_byte(8'h0A); send_byte(8'hAA);
      repeat (400) @(negedge ref_clk);
      check("write_no_response", mon_q.size(), 0);
      check("write_tx_idle", bus.tx_out, 1'b1);

      // read reg10
      send_byte(8'hBB); send_byte(8'h0A);
      expect_frame("read_reg10", 8'hAA, 1'b1);

      // 200 * 250 = 0xC350, then 200 + 250 = 0x01C2
      send_byte(8'hCC); send_byte(8'hC8); send_byte(8'hFA); send_byte(8'h02);
      expect_frame("mul_ls", 8'h50, 1'b1);
      expect_frame("mul_ms", 8'hC3, 1'b1);
      send_byte(8'hDD); send_byte(8'h00);
      expect_frame("add_ls", 8'hC2, 1'b0);
      expect_frame("add_ms", 8'h01, 1'b0);

      // PRESCALE 16, parity off
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h40);
      tb_presc = 16; tb_par_en = 1'b0;
      send_byte(8'hAA); send_byte(8'h06); send_byte(8'hAA);
      send_byte(8'hBB); send_byte(8'h06);
      expect_frame("p16_read_reg6", 8'hAA, 1'b0);
      send_byte(8'hCC); send_byte(8'hC8); send_byte(8'hFA); send_byte(8'h02);
      expect_frame("p16_mul_ls", 8'h50, 1'b0);
      expect_frame("p16_mul_ms", 8'hC3, 1'b0);

      // PRESCALE 8, parity on, XOR type: 200 / 5 = 40, 200 - 5 = 195
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h23);
      tb_presc = 8; tb_par_en = 1'b1; tb_par_type = 1'b1;
      send_byte(8'hCC); send_byte(8'hC8); send_byte(8'h05); send_byte(8'h03);
      expect_frame("p8_div_ls", 8'h28, 1'b0);
      expect_frame("p8_div_ms", 8'h00, 1'b0);
      send_byte(8'hDD); send_byte(8'h01);
      expect_frame("p8_sub_ls", 8'hC3, 1'b0);
      expect_frame("p8_sub_ms", 8'h00, 1'b0);

      // back to defaults; line errors must discard frames
      do_reset();
      check("rst2_tx_out", bus.tx_out, 1'b1);
      release_reset();
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h5A);
      send_byte(8'hBB, 1'b1, 1'b0);
      check("bad_parity_flag", {bus.parity_error, bus.stop_error}, 2'b10);
      send_byte(8'h05, 1'b0, 1'b1);
      check("bad_stop_flag", {bus.parity_error, bus.stop_error}, 2'b01);
      repeat (40) @(negedge ref_clk);

      // a low pulse shorter than half a bit is a false start
      bus.rx_in = 1'b0;
      repeat (4) @(negedge ref_clk);
      bus.rx_in = 1'b1;
      repeat (100) @(negedge ref_clk);

      send_byte(8'hBB);
      check("good_frame_clears", {bus.parity_error, bus.stop_error}, 2'b00);
      send_byte(8'h05);
      expect_frame("read_after_errors", 8'h5A, 1'b1);
      repeat (800) @(negedge ref_clk);
      check("no_extra_frames", mon_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/system_top.md
SYSTEM_TOP -- requirements
Module: system_top

Interface
REQ-001 SHALL have parameters: data_width 8 (byte width); addre_width 4 (command address width); alu_func_width 4 (ALU function code width); num_sync_stage 2 (rx_in synchronizer flops); rg_addres_width 4 (register address width); reg_file_depth 16 (register count); FIFO_DEPTH 8 (TX byte FIFO entries); FIFO_addres_width 3 (FIFO pointer width).
REQ-002 ref_clk  input  1  sole clock; all logic is on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx_in  input  1  UART serial input; idles high.
REQ-005 tx_out  output  1  UART serial output; idles high.
REQ-006 parity_error  output  1  last received frame had a bad parity bit.
REQ-007 stop_error  output  1  last received frame had a low stop bit.

Function
REQ-008 SHALL hold a 16 x 8 register file. reg0 is ALU operand A, reg1 is operand B, reg2 is UART configuration, reg3..reg15 are general purpose.
REQ-009 reg2 fields: bit0 parity enable; bit1 parity type; bits[7:2] PRESCALE, in ref_clk cycles per bit. Effective PRESCALE is the field value, or 4 if the field is below 4.
REQ-010 Frame format, in order: start bit 0, data[0] through data[7] (LSB first), optional parity bit, stop bit 1.
REQ-011 Parity bit value: if type=0, it is 1 when data has an even number of ones; if type=1, it is the XOR reduction of data.
REQ-012 rx_in SHALL pass through num_sync_stage flops before any use.
REQ-013 RX states: IDLE, START, DATA, PARITY, STOP.
  - Falling edge in IDLE captures reg2 into the RX and enters START.
  - Each bit is sampled once, PRESCALE/2 cycles into the bit.
  - A start sample of 1 is a false start and returns to IDLE.
  - After the stop sample the RX returns to IDLE at once.
REQ-014 At the stop sample, parity_error and stop_error SHALL be updated; they hold until the next frame completes. A frame with either error is discarded.
REQ-015 TX SHALL pop bytes from an 8-entry FIFO (FIFO_DEPTH), writes from the controller.
  - reg2 is captured at each start bit; each bit lasts PRESCALE cycles.
  - An internal busy is high from start through stop.
  - tx_out SHALL be high for at least one bit period between frames, so busy falls and rises again.
  - FIFO pushes while full are dropped.
REQ-016 Controller states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUNC, ALU_NOP_FUNC. Only accepted frames advance the state.
REQ-017 Commands:
  - 0xAA, then addr, then data: reg[addr[3:0]] = data; no response.
  - 0xBB, then addr: push reg[addr[3:0]].
  - 0xCC, then A, then B, then func: reg0 = A, reg1 = B, then run the ALU.
  - 0xDD, then func: run the ALU on the current reg0 and reg1.
  - Any other byte in IDLE is ignored.
REQ-018 ALU result is 16 bits; the controller pushes the LS byte, then the MS byte.
REQ-019 ALU function codes:
  - 0 A+B; 1 A-B (mod 2^16); 2 A*B; 3 A/B (0 if B=0).
  - 4 AND; 5 OR; 6 NAND; 7 NOR; 8 XOR; 9 XNOR (zero-extended).
  - 10 A==B; 11 A>B; 12 A<B (result 1 or 0).
  - 13 A>>1; 14 A<<1; 15 result 0.
REQ-020 The first TX start bit SHALL begin within 4 ref_clk cycles after the last command frame's stop sample, if TX is idle.
REQ-021 A reg2 write SHALL take effect for RX and TX frames that start after the write. Frames already in progress keep their captured configuration.

Reset
REQ-022 On rst high, immediately and asynchronously:
  - tx_out=1, parity_error=0, stop_error=0.
  - FIFO empty; RX, TX and controller in IDLE.
  - All registers 0x00, except reg2=0x81 (parity on, type 0, PRESCALE 32).
REQ-023 Reset mid-frame SHALL abort the frame; no partial write or transmit occurs.

Verification
REQ-024 After reset, send AA,0A,AA -> reg[10]=0xAA; tx_out stays high.
REQ-025 Send BB,0A -> tx_out emits an 11-bit frame with data 0xAA, parity 1, stop 1.
REQ-026 Send CC,C8,FA,02 -> two frames: 0x50 (parity 1), then 0xC3 (parity 1). Then send DD,00 -> 0xC2 (parity 0), then 0x01 (parity 0).
REQ-027 Send AA,02,40 -> PRESCALE 16, parity off. Then 10-bit frames AA,06,AA, then BB,06 -> 10-bit response 0xAA. Then CC,C8,FA,02 -> 0x50, 0xC3.
REQ-028 Send AA,02,23 -> PRESCALE 8, type 1. Then CC,C8,05,03 -> 0x28, 0x00 (parity 0 on both). Then DD,01 -> 0xC3, 0x00.
REQ-029 With default configuration, send a frame with a flipped parity bit -> parity_error=1 and the frame is ignored. Send a frame with stop bit 0 -> stop_error=1. The next good frame clears both.
